// File: rtl/prog_loader.sv
// prog_loader: boot-time writer for the core's program RAM.
// Takes a length-prefixed, checksummed byte stream, writes the payload from
// address 0 with a SETUP / STROBE / HOLD write cycle, and releases the core's
// reset only after a load whose checksum matches.
module prog_loader #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 32,
  parameter int WR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_data_oe,
  output logic              mem_wr,
  output logic              cpu_reset,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [3:0] {
    S_IDLE, S_LEN, S_DATA, S_SETUP, S_STROBE, S_HOLD, S_CHK, S_DONE, S_ERR
  } state_t;

  // Strobe counter only needs to reach WR_CYCLES-1.
  localparam int SW = (WR_CYCLES > 1) ? $clog2(WR_CYCLES) : 1;
  localparam logic [SW-1:0]     STB_LAST = SW'(WR_CYCLES - 1);
  localparam logic [DATA_W-1:0] DEPTH_B  = DATA_W'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_W    = (ADDR_W + 1)'(1);

  state_t              state_reg, state_next;
  logic [SW-1:0]       stb_cnt_reg, stb_cnt_next;
  logic [ADDR_W:0]     len_reg, len_next;
  logic [ADDR_W:0]     word_cnt_reg, word_cnt_next;
  logic [DATA_W-1:0]   checksum_reg, checksum_next;
  logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0]   mem_data_reg, mem_data_next;
  logic [ADDR_W:0]     word_cnt_inc;

  logic in_ready_reg, mem_data_oe_reg, mem_wr_reg;
  logic cpu_reset_reg, busy_reg, done_reg, err_reg;

  logic xfer;

  // A byte moves only when the registered ready meets the source's valid.
  assign xfer         = in_valid && in_ready_reg;
  assign word_cnt_inc = word_cnt_reg + ONE_W;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_next    = state_reg;
    stb_cnt_next  = stb_cnt_reg;
    len_next      = len_reg;
    word_cnt_next = word_cnt_reg;
    checksum_next = checksum_reg;
    mem_addr_next = mem_addr_reg;
    mem_data_next = mem_data_reg;
    case (state_reg)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_next    = S_LEN;
          word_cnt_next = '0;
          checksum_next = '0;
        end
      end
      S_LEN: begin
        if (xfer) begin
          // Zero or oversize length is rejected before any RAM write.
          if ((in_data == '0) || (in_data > DEPTH_B)) begin
            state_next = S_ERR;
          end else begin
            len_next   = in_data[ADDR_W:0];
            state_next = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          mem_data_next = in_data;
          mem_addr_next = word_cnt_reg[ADDR_W-1:0];
          checksum_next = checksum_reg + in_data;
          state_next    = S_SETUP;
        end
      end
      S_SETUP: begin
        stb_cnt_next = '0;
        state_next   = S_STROBE;
      end
      S_STROBE: begin
        if (stb_cnt_reg == STB_LAST) state_next = S_HOLD;
        else                         stb_cnt_next = stb_cnt_reg + 1'b1;
      end
      S_HOLD: begin
        word_cnt_next = word_cnt_inc;
        state_next    = (word_cnt_inc == len_reg) ? S_CHK : S_DATA;
      end
      S_CHK: begin
        if (xfer) state_next = (in_data == checksum_reg) ? S_DONE : S_ERR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stb_cnt_reg  <= '0;
      len_reg      <= '0;
      word_cnt_reg <= '0;
      checksum_reg <= '0;
      mem_addr_reg <= '0;
      mem_data_reg <= '0;
    end else begin
      stb_cnt_reg  <= stb_cnt_next;
      len_reg      <= len_next;
      word_cnt_reg <= word_cnt_next;
      checksum_reg <= checksum_next;
      mem_addr_reg <= mem_addr_next;
      mem_data_reg <= mem_data_next;
    end
  end

  // Control outputs, registered from the upcoming state so each one is
  // valid for exactly the cycles spent in the corresponding state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_reg    <= 1'b0;
      mem_data_oe_reg <= 1'b0;
      mem_wr_reg      <= 1'b0;
      cpu_reset_reg   <= 1'b1;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
    end else begin
      in_ready_reg    <= (state_next == S_LEN) || (state_next == S_DATA) ||
                         (state_next == S_CHK);
      mem_data_oe_reg <= (state_next == S_SETUP) || (state_next == S_STROBE) ||
                         (state_next == S_HOLD);
      mem_wr_reg      <= (state_next == S_STROBE);
      cpu_reset_reg   <= (state_next != S_DONE);
      busy_reg        <= (state_next != S_IDLE) && (state_next != S_DONE) &&
                         (state_next != S_ERR);
      done_reg        <= (state_next == S_DONE);
      err_reg         <= (state_next == S_ERR);
    end
  end

  assign in_ready    = in_ready_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_data    = mem_data_reg;
  assign mem_data_oe = mem_data_oe_reg;
  assign mem_wr      = mem_wr_reg;
  assign cpu_reset   = cpu_reset_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign err         = err_reg;
  assign word_cnt    = word_cnt_reg;
  assign checksum    = checksum_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: the driver queues expected RAM writes and
// end-of-load status; monitors pop and compare when the DUT presents them.
module tb_prog_loader;
  localparam int ADDR_W    = 5;
  localparam int DATA_W    = 8;
  localparam int DEPTH     = 32;
  localparam int WR_CYCLES = 2;
  localparam int GAP       = 5;   // WR_CYCLES + 3

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_data_oe, mem_wr, cpu_reset, busy, done, err;
  logic [ADDR_W:0]   word_cnt;
  logic [DATA_W-1:0] checksum;

  prog_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .WR_CYCLES(WR_CYCLES)) dut (
    .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_data_oe(mem_data_oe), .mem_wr(mem_wr), .cpu_reset(cpu_reset),
    .busy(busy), .done(done), .err(err), .word_cnt(word_cnt), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int pass_cnt = 0;
  int total_cnt = 0;

  // expected write: {addr, data}; expected status: {done, err, word_cnt, checksum}
  logic [12:0] wr_q[$];
  logic [15:0] st_q[$];

  logic [7:0] pay[0:31];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Write monitor: one line per observed RAM write.
  logic prev_wr = 1'b0;
  int   wr_width = 0;
  bit   in_pulse = 1'b0;
  always @(negedge clk) begin
    logic [12:0] e;
    if (rst) begin
      in_pulse = 1'b0;
      wr_width = 0;
    end else begin
      if (mem_wr && !prev_wr) begin
        in_pulse = 1'b1;
        wr_width = 0;
        if (wr_q.size() == 0) begin
          chk("unexpected_write", {19'd0, mem_addr, mem_data}, 32'h1fff);
        end else begin
          e = wr_q.pop_front();
          $display("write addr=%02h data=%02h (exp %02h/%02h)", mem_addr, mem_data, e[12:8], e[7:0]);
          chk("wr_addr", {27'd0, mem_addr}, {27'd0, e[12:8]});
          chk("wr_data", {24'd0, mem_data}, {24'd0, e[7:0]});
        end
        chk("wr_oe", {31'd0, mem_data_oe}, 32'd1);
        chk("wr_ready_low", {31'd0, in_ready}, 32'd0);
      end
      if (mem_wr) wr_width++;
      if (!mem_wr && prev_wr && in_pulse) begin
        chk("wr_width", wr_width, WR_CYCLES);
        in_pulse = 1'b0;
      end
    end
    prev_wr = mem_wr;
  end

  // Status monitor: compares when done or err rises.
  logic prev_done = 1'b0, prev_err = 1'b0;
  always @(negedge clk) begin
    logic [15:0] s;
    if (!rst && ((done && !prev_done) || (err && !prev_err))) begin
      if (st_q.size() == 0) begin
        chk("unexpected_status", {30'd0, done, err}, 32'hffff);
      end else begin
        s = st_q.pop_front();
        $display("status done=%0b err=%0b word_cnt=%02h checksum=%02h cpu_reset=%0b",
                 done, err, word_cnt, checksum, cpu_reset);
        chk("st_done", {31'd0, done}, {31'd0, s[15]});
        chk("st_err", {31'd0, err}, {31'd0, s[14]});
        chk("st_word_cnt", {26'd0, word_cnt}, {26'd0, s[13:8]});
        chk("st_checksum", {24'd0, checksum}, {24'd0, s[7:0]});
        chk("st_cpu_reset", {31'd0, cpu_reset}, {31'd0, ~s[15]});
        chk("st_busy", {31'd0, busy}, 32'd0);
      end
    end
    prev_done = done;
    prev_err  = err;
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present one byte and hold it until accepted; returns the acceptance cycle.
  task automatic send(input logic [7:0] b, output int acc);
    int n;
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", n, 0);
    @(posedge clk); #1;
    acc = cyc;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    @(negedge clk);
    while (!(done || err) && n < 400) begin
      n++;
      @(negedge clk);
    end
    if (!(done || err)) chk("end_timeout", n, 0);
    @(posedge clk); #1;
  endtask

  // Full stream from pay[0..len-1]; exp values hand-supplied by the caller.
  task automatic run_stream(input int len, input logic [7:0] ck, input bit ok,
                            input logic [7:0] exp_sum, input bit mid_start);
    int a, prev;
    st_q.push_back({ok, ~ok, 6'(len), exp_sum});
    for (int i = 0; i < len; i++) wr_q.push_back({5'(i), pay[i]});
    do_start();
    send(8'(len), a);
    for (int i = 0; i < len; i++) begin
      prev = a;
      send(pay[i], a);
      if (i > 0) chk("accept_gap", a - prev, GAP);
      if (mid_start && i == 1) begin
        start = 1'b1;
        fork begin @(posedge clk); #1; start = 1'b0; end join_none
      end
    end
    prev = a;
    send(ck, a);
    chk("chk_gap", a - prev, GAP);
    in_valid = 1'b0;
    wait_end();
  endtask

  task automatic bad_len(input logic [7:0] len);
    int a;
    st_q.push_back({1'b0, 1'b1, 6'd0, 8'd0});
    do_start();
    send(len, a);
    @(negedge clk);
    chk("ready_after_badlen", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b0;
    wait_end();
  endtask

  initial begin
    int a;
    repeat (3) @(negedge clk);
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_outputs", {busy, done, err, mem_wr, mem_data_oe, in_ready, word_cnt, checksum, mem_addr, mem_data},
        32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Length 3, good checksum.
    pay[0] = 8'hA0; pay[1] = 8'hB1; pay[2] = 8'hC2;
    run_stream(3, 8'h13, 1'b1, 8'h13, 1'b0);
    // Same payload, bad checksum.
    run_stream(3, 8'h14, 1'b0, 8'h13, 1'b0);
    // Illegal lengths.
    bad_len(8'h00);
    bad_len(8'h21);
    // Full 32-byte load.
    for (int i = 0; i < 32; i++) pay[i] = 8'(i);
    run_stream(32, 8'hF0, 1'b1, 8'hF0, 1'b0);
    chk("full_last_addr", {27'd0, mem_addr}, 32'h1F);
    // Continuous valid with a stray start mid-load.
    pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
    run_stream(4, 8'hAA, 1'b1, 8'hAA, 1'b1);

    // Reset during the second write strobe.
    wr_q.push_back({5'd0, 8'hA0});
    wr_q.push_back({5'd1, 8'hB1});
    do_start();
    send(8'h03, a);
    send(8'hA0, a);
    send(8'hB1, a);
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!mem_wr && n < 20) begin n++; @(negedge clk); end
      chk("strobe_seen", {31'd0, mem_wr}, 32'd1);
    end
    #2 rst = 1'b1;
    #1;
    $display("reset mid-load mem_wr=%0b cpu_reset=%0b busy=%0b", mem_wr, cpu_reset, busy);
    chk("midrst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("midrst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("midrst_outputs", {busy, done, err, mem_data_oe, in_ready, word_cnt, checksum, mem_addr, mem_data},
        32'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reload from address 0 after reset.
    pay[0] = 8'hA0; pay[1] = 8'hB1; pay[2] = 8'hC2;
    run_stream(3, 8'h13, 1'b1, 8'h13, 1'b0);

    repeat (4) @(posedge clk);
    chk("wr_q_empty", wr_q.size(), 0);
    chk("st_q_empty", st_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
